// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding and counter sizing.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IF_ACC  = 2'd1;
  localparam logic [1:0] ST_MEM_ACC = 2'd2;
  localparam logic [1:0] ST_IF_DROP = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    IF_ACC  = ST_IF_ACC,
    MEM_ACC = ST_MEM_ACC,
    IF_DROP = ST_IF_DROP
  } arb_state_e;

  // Wait counter width: enough to hold MAX_WAIT, never narrower than 8 bits.
  function automatic int unsigned wait_cnt_width(int unsigned max_wait);
    int unsigned w;
    w = $clog2(max_wait + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester/memory-side signal bundle for the fetch/data memory arbiter.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              flush_if;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_rdata;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              bus_err;
  logic              stall_if;
  logic              stall_mem;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, flush_if, mem_req, mem_we, mem_addr, mem_wdata,
           bus_ready, bus_rdata,
    output bus_req, bus_we, bus_addr, bus_wdata, if_valid, if_rdata,
           mem_valid, mem_rdata, bus_err, stall_if, stall_mem
  );

  // Pipeline requesters plus memory view.
  modport master (
    output if_req, if_addr, flush_if, mem_req, mem_we, mem_addr, mem_wdata,
           bus_ready, bus_rdata,
    input  bus_req, bus_we, bus_addr, bus_wdata, if_valid, if_rdata,
           mem_valid, mem_rdata, bus_err, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// access; data wins, fetches can be flushed, stuck accesses time out.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic      clk,
  input  logic      rst,
  mem_arb_if.slave  bus
);

  localparam int unsigned CNT_W = wait_cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  // A requester whose done pulse is high this cycle is still holding the old request.
  logic mem_go, if_go, at_limit;
  assign mem_go   = bus.mem_req && !mem_valid_q;
  assign if_go    = bus.if_req && !if_valid_q && !bus.flush_if;
  assign at_limit = (cnt_q == CNT_MAX);

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Grant, completion, flush and timeout decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (mem_go) begin
          state_d     = MEM_ACC;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = bus.mem_we;
          bus_addr_d  = bus.mem_addr;
          bus_wdata_d = bus.mem_wdata;
        end else if (if_go) begin
          state_d    = IF_ACC;
          cnt_d      = '0;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = bus.if_addr;
        end
      end

      IF_ACC: begin
        if (bus.flush_if) begin
          // Flushed fetch: finish the bus cycle quietly, never report it.
          if (bus.bus_ready) begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
          end else begin
            state_d = IF_DROP;
            cnt_d   = at_limit ? cnt_q : cnt_q + 1'b1;
          end
        end else if (bus.bus_ready) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = bus.bus_rdata;
        end else if (at_limit) begin
          state_d    = IDLE;
          bus_req_d  = 1'b0;
          if_valid_d = 1'b1;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      MEM_ACC: begin
        if (bus.bus_ready) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          mem_valid_d = 1'b1;
          if (!bus_we_q) mem_rdata_d = bus.bus_rdata;
        end else if (at_limit) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          mem_valid_d = 1'b1;
          bus_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      IF_DROP: begin
        // Nobody is waiting on this access, so a timeout here is silent.
        if (bus.bus_ready || (cnt_q >= CNT_MAX)) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Output drive.
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.stall_if  = bus.if_req && !if_valid_q;
  assign bus.stall_mem = bus.mem_req && !mem_valid_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized
// transactions checked against a transaction-level expectation model.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int MW = 4;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.flush_if  = 1'b0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset bus_req: got %b want 0", bus_if.bus_req); end
    n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL reset bus_we: got %b want 0", bus_if.bus_we); end
    n_cmp++; if (bus_if.bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset bus_addr: got %h want 0", bus_if.bus_addr); end
    n_cmp++; if (bus_if.bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset bus_wdata: got %h want 0", bus_if.bus_wdata); end
    n_cmp++; if ({bus_if.if_valid, bus_if.mem_valid, bus_if.bus_err} !== 3'b000) begin n_fail++; $display("FAIL reset pulses: got %b want 000", {bus_if.if_valid, bus_if.mem_valid, bus_if.bus_err}); end
    n_cmp++; if (bus_if.if_rdata !== 32'h0) begin n_fail++; $display("FAIL reset if_rdata: got %h want 0", bus_if.if_rdata); end
    n_cmp++; if (bus_if.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset mem_rdata: got %h want 0", bus_if.mem_rdata); end
    exp_if_rdata  = 32'h0;
    exp_mem_rdata = 32'h0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h100;
    bus_if.if_req  = 1'b1; bus_if.if_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h100) begin n_fail++; $display("FAIL prio mem_grant: got req=%b addr=%h want req=1 addr=100", bus_if.bus_req, bus_if.bus_addr); end
    n_cmp++; if (bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL prio mem_we: got %b want 0", bus_if.bus_we); end
    n_cmp++; if ({bus_if.stall_mem, bus_if.stall_if} !== 2'b11) begin n_fail++; $display("FAIL prio stalls: got %b want 11", {bus_if.stall_mem, bus_if.stall_if}); end
    @(negedge clk);
    @(negedge clk);
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    n_cmp++; if (bus_if.mem_valid !== 1'b1 || bus_if.if_valid !== 1'b0) begin n_fail++; $display("FAIL prio mem_valid: got mem=%b if=%b want mem=1 if=0", bus_if.mem_valid, bus_if.if_valid); end
    n_cmp++; if (bus_if.mem_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL prio mem_rdata: got %h want deadbeef", bus_if.mem_rdata); end
    n_cmp++; if (bus_if.stall_mem !== 1'b0 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL prio done_cycle: got stall_mem=%b bus_req=%b want 0 0", bus_if.stall_mem, bus_if.bus_req); end
    exp_mem_rdata = 32'hDEADBEEF;
    bus_if.mem_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h40 || bus_if.bus_we !== 1'b0) begin n_fail++; $display("FAIL prio if_grant: got req=%b addr=%h we=%b want 1 40 0", bus_if.bus_req, bus_if.bus_addr, bus_if.bus_we); end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h11111111;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    n_cmp++; if (bus_if.if_valid !== 1'b1 || bus_if.if_rdata !== 32'h11111111) begin n_fail++; $display("FAIL prio if_done: got valid=%b data=%h want 1 11111111", bus_if.if_valid, bus_if.if_rdata); end
    exp_if_rdata = 32'h11111111;
    bus_if.if_req = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h40) begin n_fail++; $display("FAIL fetch grant: got req=%b addr=%h want 1 40", bus_if.bus_req, bus_if.bus_addr); end
    n_cmp++; if (bus_if.if_valid !== 1'b0 || bus_if.stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch wait: got valid=%b stall=%b want 0 1", bus_if.if_valid, bus_if.stall_if); end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h00000013;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    n_cmp++; if (bus_if.if_valid !== 1'b1 || bus_if.if_rdata !== 32'h00000013) begin n_fail++; $display("FAIL fetch done: got valid=%b data=%h want 1 00000013", bus_if.if_valid, bus_if.if_rdata); end
    n_cmp++; if (bus_if.stall_if !== 1'b0) begin n_fail++; $display("FAIL fetch stall_if: got %b want 0", bus_if.stall_if); end
    exp_if_rdata = 32'h00000013;
    bus_if.if_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch pulse_width: got %b want 0", bus_if.if_valid); end
  endtask

  task automatic test_flush();
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h80;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h80) begin n_fail++; $display("FAIL flush grant: got req=%b addr=%h want 1 80", bus_if.bus_req, bus_if.bus_addr); end
    @(negedge clk);
    bus_if.flush_if = 1'b1;
    @(negedge clk);
    bus_if.flush_if = 1'b0; bus_if.if_req = 1'b0;
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_we !== 1'b0 || bus_if.if_valid !== 1'b0) begin n_fail++; $display("FAIL flush drop_hold: got req=%b we=%b valid=%b want 1 0 0", bus_if.bus_req, bus_if.bus_we, bus_if.if_valid); end
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.if_valid !== 1'b0) begin n_fail++; $display("FAIL flush drop_wait: got req=%b valid=%b want 1 0", bus_if.bus_req, bus_if.if_valid); end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hBADC0DE0;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    n_cmp++; if (bus_if.bus_req !== 1'b0 || bus_if.if_valid !== 1'b0) begin n_fail++; $display("FAIL flush end: got req=%b valid=%b want 0 0", bus_if.bus_req, bus_if.if_valid); end
    n_cmp++; if (bus_if.if_rdata !== exp_if_rdata) begin n_fail++; $display("FAIL flush if_rdata: got %h want %h", bus_if.if_rdata, exp_if_rdata); end
    @(negedge clk);
    n_cmp++; if (bus_if.if_valid !== 1'b0 || bus_if.bus_err !== 1'b0) begin n_fail++; $display("FAIL flush after: got valid=%b err=%b want 0 0", bus_if.if_valid, bus_if.bus_err); end
  endtask

  task automatic test_timeout();
    int  acc;
    logic seen;
    acc = 0; seen = 1'b0;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1;
    bus_if.mem_addr = 32'h200; bus_if.mem_wdata = 32'h12345678;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.mem_valid === 1'b1) seen = 1'b1;
      else if (bus_if.bus_req === 1'b1) begin
        acc++;
        n_cmp++; if (bus_if.bus_we !== 1'b1 || bus_if.bus_wdata !== 32'h12345678 || bus_if.bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout access: got we=%b wdata=%h err=%b want 1 12345678 0", bus_if.bus_we, bus_if.bus_wdata, bus_if.bus_err); end
      end
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL timeout no_valid: got %b want 1", seen); end
    n_cmp++; if (acc != MW + 1) begin n_fail++; $display("FAIL timeout cycles: got %0d want %0d", acc, MW + 1); end
    n_cmp++; if (bus_if.bus_err !== 1'b1 || bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL timeout err: got err=%b req=%b want 1 0", bus_if.bus_err, bus_if.bus_req); end
    n_cmp++; if (bus_if.mem_rdata !== exp_mem_rdata) begin n_fail++; $display("FAIL timeout mem_rdata: got %h want %h", bus_if.mem_rdata, exp_mem_rdata); end
    bus_if.mem_req = 1'b0; bus_if.mem_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_err !== 1'b0 || bus_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL timeout pulse_width: got err=%b valid=%b want 0 0", bus_if.bus_err, bus_if.mem_valid); end
  endtask

  task automatic test_reset_mid();
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h300;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("FAIL rstmid grant: got %b want 1", bus_if.bus_req); end
    @(negedge clk);
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hCAFEF00D;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid bus_req_async: got %b want 0", bus_if.bus_req); end
    exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0; bus_if.bus_ready = 1'b0; bus_if.mem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus_if.mem_valid !== 1'b0 || bus_if.bus_req !== 1'b0 || bus_if.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid quiet: got valid=%b req=%b rdata=%h want 0 0 0", bus_if.mem_valid, bus_if.bus_req, bus_if.mem_rdata); end
    end
    bus_if.mem_req = 1'b1; bus_if.mem_addr = 32'h304;
    @(negedge clk);
    n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 32'h304) begin n_fail++; $display("FAIL rstmid regrant: got req=%b addr=%h want 1 304", bus_if.bus_req, bus_if.bus_addr); end
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus_if.bus_ready = 1'b0;
    n_cmp++; if (bus_if.mem_valid !== 1'b1 || bus_if.mem_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstmid redo: got valid=%b data=%h want 1 0badf00d", bus_if.mem_valid, bus_if.mem_rdata); end
    exp_mem_rdata = 32'h0BADF00D;
    bus_if.mem_req = 1'b0;
  endtask

  task automatic test_random();
    int   kind, lat, n_g;
    logic is_mem, got, timed_out, m_we, want_we;
    logic [31:0] f_addr, m_addr, m_wdata, rd, want_addr;
    for (int t = 0; t < 40; t++) begin
      kind    = int'($urandom_range(2, 0));
      f_addr  = $urandom;
      m_addr  = $urandom;
      m_wdata = $urandom;
      m_we    = 1'(($urandom >> 3) & 1);
      rd      = '0;
      @(negedge clk);
      bus_if.if_req    = (kind != 1);
      bus_if.if_addr   = f_addr;
      bus_if.mem_req   = (kind != 0);
      bus_if.mem_we    = m_we;
      bus_if.mem_addr  = m_addr;
      bus_if.mem_wdata = m_wdata;
      n_g = (kind == 2) ? 2 : 1;
      for (int g = 0; g < n_g; g++) begin
        is_mem    = (kind == 1) || (kind == 2 && g == 0);
        want_addr = is_mem ? m_addr : f_addr;
        want_we   = is_mem ? m_we : 1'b0;
        lat       = int'($urandom_range(MW + 2, 0));
        timed_out = (lat > MW);
        got = 1'b0;
        for (int w = 0; w < 8 && !got; w++) begin
          @(negedge clk);
          got = (bus_if.bus_req === 1'b1);
        end
        n_cmp++; if (!got) begin n_fail++; $display("FAIL rand[%0d] grant_timeout: got no bus_req want grant", t); end
        n_cmp++; if (bus_if.bus_addr !== want_addr || bus_if.bus_we !== want_we) begin n_fail++; $display("FAIL rand[%0d] grant_cmd: got addr=%h we=%b want addr=%h we=%b", t, bus_if.bus_addr, bus_if.bus_we, want_addr, want_we); end
        if (is_mem && m_we) begin
          n_cmp++; if (bus_if.bus_wdata !== m_wdata) begin n_fail++; $display("FAIL rand[%0d] wdata: got %h want %h", t, bus_if.bus_wdata, m_wdata); end
        end
        for (int i = 0; i <= MW; i++) begin
          if (i == lat) begin
            rd = $urandom;
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = rd;
          end
          @(negedge clk);
          bus_if.bus_ready = 1'b0;
          if (i == lat) break;
          if (i < MW) begin
            n_cmp++; if (bus_if.bus_req !== 1'b1 || bus_if.if_valid !== 1'b0 || bus_if.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rand[%0d] hold: got req=%b ifv=%b memv=%b want 1 0 0", t, bus_if.bus_req, bus_if.if_valid, bus_if.mem_valid); end
          end
        end
        if (!timed_out) begin
          if (is_mem) begin
            if (!m_we) exp_mem_rdata = rd;
          end else begin
            exp_if_rdata = rd;
          end
        end
        n_cmp++; if (bus_if.mem_valid !== is_mem || bus_if.if_valid !== !is_mem) begin n_fail++; $display("FAIL rand[%0d] valid: got memv=%b ifv=%b want memv=%b ifv=%b", t, bus_if.mem_valid, bus_if.if_valid, is_mem, !is_mem); end
        n_cmp++; if (bus_if.bus_err !== timed_out) begin n_fail++; $display("FAIL rand[%0d] bus_err: got %b want %b", t, bus_if.bus_err, timed_out); end
        n_cmp++; if (bus_if.mem_rdata !== exp_mem_rdata || bus_if.if_rdata !== exp_if_rdata) begin n_fail++; $display("FAIL rand[%0d] rdata: got mem=%h if=%h want mem=%h if=%h", t, bus_if.mem_rdata, bus_if.if_rdata, exp_mem_rdata, exp_if_rdata); end
        if (is_mem) begin
          bus_if.mem_req = 1'b0; bus_if.mem_we = 1'b0;
        end else begin
          bus_if.if_req = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_fetch();
    test_flush();
    test_timeout();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter MAX_WAIT, default 255, bus-wait cycles before timeout abort.
REQ-004 SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have the following ports:
- if_req  in  1  fetch request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- flush_if  in  1  cancels the pending or in-flight fetch.
- mem_req  in  1  data request, level, held until mem_valid.
- mem_we  in  1  data write enable.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- bus_req  out  1  shared single-port memory request.
- bus_we  out  1  memory write enable.
- bus_addr  out  ADDR_W  memory address.
- bus_wdata  out  DATA_W  memory write data.
- bus_ready  in  1  memory completes the current access this cycle.
- bus_rdata  in  DATA_W  memory read data, valid with bus_ready.
- if_valid  out  1  one-cycle fetch-done pulse.
- if_rdata  out  DATA_W  fetched word; holds its value until the next fetch completes.
- mem_valid  out  1  one-cycle data-done pulse.
- mem_rdata  out  DATA_W  loaded word; holds its value until the next load completes.
- bus_err  out  1  one-cycle pulse coincident with a timed-out access's valid pulse.
- stall_if  out  1  fetch side must hold PC and IF/ID.
- stall_mem  out  1  data side must hold the whole pipeline.

Function
REQ-006 SHALL implement FSM states IDLE, IF_ACC, MEM_ACC, IF_DROP.
REQ-007 SHALL, in IDLE, go to MEM_ACC if mem_req, else to IF_ACC if if_req && !flush_if, else stay in IDLE; data has fixed priority over fetch.
REQ-008 SHALL ignore a requester's req in the same cycle its own valid is high, so the same request is not re-granted.
REQ-009 SHALL register bus_req/bus_we/bus_addr/bus_wdata on the grant edge and hold them constant through the access state; bus_we SHALL be 0 in IF_ACC and IF_DROP.
REQ-010 SHALL, when bus_ready is high in IF_ACC or MEM_ACC, capture bus_rdata into the matching rdata register (reads only; a write leaves mem_rdata unchanged), return to IDLE, and pulse the matching valid in the next cycle; latency = bus_ready cycle + 1.
REQ-011 SHALL, when flush_if is high in IF_ACC, go to IF_DROP (or directly to IDLE if bus_ready is also high) and suppress if_valid for that fetch.
REQ-012 SHALL, in IF_DROP, keep bus_req high until bus_ready, then go to IDLE with no if_valid and if_rdata unchanged.
REQ-013 SHALL count wait cycles in each access state starting from 0 at grant; at count == MAX_WAIT without bus_ready, abort to IDLE and pulse the valid together with bus_err; rdata is unchanged.
REQ-014 SHALL drive stall_if = if_req && !if_valid, combinationally.
REQ-015 SHALL drive stall_mem = mem_req && !mem_valid, combinationally.
REQ-016 SHALL use an 8-bit-wide-or-larger counter sized as clog2(MAX_WAIT+1), with no wrap-around before the abort.

Reset
REQ-017 SHALL, on rst, asynchronously force IDLE, clear the counter, and clear bus_req, bus_we, if_valid, mem_valid and bus_err.
REQ-018 SHALL, on rst, clear bus_addr, bus_wdata, if_rdata and mem_rdata to 0.
REQ-019 SHALL drop bus_req immediately on a reset that occurs mid-access; any in-flight response is discarded.

Structure
REQ-020 SHALL place the FSM state encoding (2-bit localparams) in the shared CPU constants include, alongside the existing write-back select codes.
REQ-021 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-022 SHALL cover: both requests in IDLE, MEM read addr 0x100, bus_ready after 2 cycles with rdata 0xDEADBEEF -> MEM granted first, mem_valid with mem_rdata 0xDEADBEEF, then IF granted after one IDLE cycle.
REQ-023 SHALL cover: fetch 0x40 with bus_ready on the first cycle and rdata 0x00000013 -> if_valid 2 cycles after grant, stall_if low in the if_valid cycle.
REQ-024 SHALL cover: flush_if on the 2nd cycle of IF_ACC, bus_ready on the 4th -> IF_DROP entered, no if_valid, if_rdata unchanged.
REQ-025 SHALL cover: MEM write with bus_ready never asserted, MAX_WAIT = 4 -> abort after 5 access cycles, mem_valid and bus_err pulse together.
REQ-026 SHALL cover: rst asserted mid-MEM_ACC -> bus_req low the same cycle, IDLE after release, no valid pulse.
